// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave returns results.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub with the carry chain cut into CHUNK-bit slices,
// one slice resolved per pipeline stage; latency WIDTH/CHUNK cycles.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic rst,
  pipelined_adder_if.slave bus
);

  localparam int NSTAGE = (CHUNK < 1) ? 1 : WIDTH / CHUNK;

  generate
    if ((CHUNK < 1) ||
        (WIDTH % ((CHUNK < 1) ? 1 : CHUNK) != 0)) begin : g_bad
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK >= 1");
    end
  endgenerate

  logic             v_q   [NSTAGE];
  logic             c_q   [NSTAGE];
  logic [WIDTH-1:0] s_q   [NSTAGE];
  logic [WIDTH-1:0] a_q   [NSTAGE];
  logic [WIDTH-1:0] b_q   [NSTAGE];
  logic             ovf_q;

  logic             src_v [NSTAGE];
  logic             src_c [NSTAGE];
  logic [WIDTH-1:0] src_a [NSTAGE];
  logic [WIDTH-1:0] src_b [NSTAGE];
  logic [WIDTH-1:0] src_s [NSTAGE];
  logic [WIDTH-1:0] n_s   [NSTAGE];
  logic             n_c   [NSTAGE];
  logic [CHUNK:0]   t;
  logic             n_ovf;
  logic             stall;

  assign stall         = v_q[NSTAGE-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v_q[NSTAGE-1];
  assign bus.s         = s_q[NSTAGE-1];
  assign bus.cout      = c_q[NSTAGE-1];
  assign bus.ovf       = ovf_q;

  // Stage k consumes what stage k-1 registered; stage 0 eats the inputs.
  always_comb begin
    src_v[0] = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub ? 1'b1 : bus.cin;
    src_s[0] = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
    end
    t = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      t = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
        + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, src_c[k]};
      n_s[k] = src_s[k];
      n_s[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      n_c[k] = t[CHUNK];
    end
    // carry into the MSB recovered from the MSB sum bit
    n_ovf = src_a[NSTAGE-1][WIDTH-1] ^ src_b[NSTAGE-1][WIDTH-1]
          ^ n_s[NSTAGE-1][WIDTH-1] ^ n_c[NSTAGE-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          c_q[k] <= n_c[k];
          s_q[k] <= n_s[k];
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
        end
      end
      if (src_v[NSTAGE-1]) ovf_q <= n_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks of pipelined_adder in three parameterisations:
// 32/8 (main), 32/32 (single stage) and 4/1 (exhaustive).
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus8 ();
  pipelined_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave));
  pipelined_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32.slave));
  pipelined_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  // {ovf, cout, s}
  function automatic logic [33:0] model32(
    logic [31:0] a, logic [31:0] b, logic ci, logic sb);
    logic [31:0] bb;
    logic [32:0] r;
    logic        ov;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
    ov = (a[31] == bb[31]) && (r[31] != a[31]);
    return {ov, r};
  endfunction

  function automatic logic [5:0] model4(
    logic [3:0] a, logic [3:0] b, logic ci, logic sb);
    logic [3:0] bb;
    logic [4:0] r;
    logic       ov;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {4'd0, (sb ? 1'b1 : ci)};
    ov = (a[3] == bb[3]) && (r[3] != a[3]);
    return {ov, r};
  endfunction

  task automatic do_op8(input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb,
                        output logic [31:0] s, output logic co,
                        output logic ov, output int lat);
    @(posedge clk); #1;
    bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.sub = sb;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = bus8.s; co = bus8.cout; ov = bus8.ovf;
  endtask

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co,
                         output logic ov, output int lat);
    @(posedge clk); #1;
    bus32.a = a; bus32.b = b; bus32.cin = ci; bus32.sub = sb;
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = bus32.s; co = bus32.cout; ov = bus32.ovf;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (bus8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got %b want 0", bus8.out_valid);
    end
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready got %b want 1", bus8.in_ready);
    end
    n_cmp++;
    if (bus8.s !== 32'h0) begin
      n_bad++; $display("FAIL rst_s got %h want 0", bus8.s);
    end
    n_cmp++;
    if ({bus8.cout, bus8.ovf} !== 2'b00) begin
      n_bad++; $display("FAIL rst_flags got %b%b want 00", bus8.cout, bus8.ovf);
    end
    n_cmp++;
    if (bus4.out_valid !== 1'b0 || bus32.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_other_valid got %b%b want 00",
                        bus4.out_valid, bus32.out_valid);
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_carry();
    logic [31:0] s; logic co, ov; int lat;
    do_op8(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, s, co, ov, lat);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL carry_lat got %0d want 4", lat); end
    n_cmp++;
    if (s !== 32'h0) begin n_bad++; $display("FAIL carry_s got %h want 00000000", s); end
    n_cmp++;
    if (co !== 1'b1) begin n_bad++; $display("FAIL carry_cout got %b want 1", co); end
    n_cmp++;
    if (ov !== 1'b0) begin n_bad++; $display("FAIL carry_ovf got %b want 0", ov); end
  endtask

  task automatic test_overflow();
    logic [31:0] s; logic co, ov; int lat;
    do_op8(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
    n_cmp++;
    if (s !== 32'h80000000) begin n_bad++; $display("FAIL ovf1_s got %h want 80000000", s); end
    n_cmp++;
    if ({co, ov} !== 2'b01) begin n_bad++; $display("FAIL ovf1_flags got %b%b want 01", co, ov); end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL ovf1_lat got %0d want 4", lat); end
    do_op8(32'h80000000, 32'h80000000, 1'b0, 1'b0, s, co, ov, lat);
    n_cmp++;
    if (s !== 32'h0) begin n_bad++; $display("FAIL ovf2_s got %h want 00000000", s); end
    n_cmp++;
    if ({co, ov} !== 2'b11) begin n_bad++; $display("FAIL ovf2_flags got %b%b want 11", co, ov); end
  endtask

  task automatic test_subtract();
    logic [31:0] s; logic co, ov; int lat;
    do_op8(32'd5, 32'd7, 1'b1, 1'b1, s, co, ov, lat);
    n_cmp++;
    if (s !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL sub1_s got %h want fffffffe", s); end
    n_cmp++;
    if ({co, ov} !== 2'b00) begin n_bad++; $display("FAIL sub1_flags got %b%b want 00", co, ov); end
    do_op8(32'd7, 32'd5, 1'b0, 1'b1, s, co, ov, lat);
    n_cmp++;
    if (s !== 32'd2) begin n_bad++; $display("FAIL sub2_s got %h want 00000002", s); end
    n_cmp++;
    if ({co, ov} !== 2'b10) begin n_bad++; $display("FAIL sub2_flags got %b%b want 10", co, ov); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF,
                            32'h80000000, 32'h00000001, 32'h7FFFFFFF,
                            32'hDEADBEEF, 32'h0F0F0F0F};
    logic [31:0] vb [8] = '{32'h87654321, 32'h11111111, 32'hFFFFFFFF,
                            32'h00000001, 32'h00000002, 32'h7FFFFFFF,
                            32'h01234567, 32'hF0F0F0F0};
    logic vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic vc [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [33:0] q [$];
    logic [33:0] e;
    logic [31:0] hold_s;
    logic        stall_exp;
    int issued = 0;
    int got = 0;
    hold_s = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(posedge clk); #1;
      stall_exp = (cyc >= 6 && cyc <= 8);
      bus8.out_ready = !stall_exp;
      bus8.in_valid  = (issued < 8);
      if (issued < 8) begin
        bus8.a = va[issued]; bus8.b = vb[issued];
        bus8.sub = vs[issued]; bus8.cin = vc[issued];
      end
      #1;
      n_cmp++;
      if (bus8.in_ready !== !stall_exp) begin
        n_bad++; $display("FAIL b2b_in_ready cyc %0d got %b want %b",
                          cyc, bus8.in_ready, !stall_exp);
      end
      if (cyc == 6) hold_s = bus8.s;
      if (cyc == 7 || cyc == 8) begin
        n_cmp++;
        if (bus8.out_valid !== 1'b1 || bus8.s !== hold_s) begin
          n_bad++; $display("FAIL b2b_hold cyc %0d got v=%b s=%h want v=1 s=%h",
                            cyc, bus8.out_valid, bus8.s, hold_s);
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q.push_back(model32(va[issued], vb[issued], vc[issued], vs[issued]));
        issued++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 34'h3_DEAD_DEAD;
        n_cmp++;
        if ({bus8.ovf, bus8.cout, bus8.s} !== e) begin
          n_bad++; $display("FAIL b2b_result %0d got %h want %h",
                            got, {bus8.ovf, bus8.cout, bus8.s}, e);
        end
        got++;
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    n_cmp++;
    if (got !== 8 || q.size() !== 0) begin
      n_bad++; $display("FAIL b2b_count got %0d left %0d want 8 left 0", got, q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic co, ov; int lat;
    int stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus8.a = 32'h100 + i; bus8.b = 32'h1; bus8.sub = 1'b0; bus8.cin = 1'b0;
      bus8.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_valid got %b want 0", bus8.out_valid);
    end
    n_cmp++;
    if (bus8.s !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_s got %h want 0", bus8.s);
    end
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_in_ready got %b want 1", bus8.in_ready);
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_bad++; $display("FAIL rstmid_stale got %0d want 0", stale);
    end
    do_op8(32'h10, 32'h20, 1'b0, 1'b0, s, co, ov, lat);
    n_cmp++;
    if (s !== 32'h30 || lat !== 4) begin
      n_bad++; $display("FAIL rstmid_op got s=%h lat=%0d want s=00000030 lat=4", s, lat);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_after got %b want 0", bus8.out_valid);
    end
  endtask

  task automatic test_single_stage();
    logic [31:0] s; logic co, ov; int lat;
    do_op32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL c32_lat got %0d want 1", lat); end
    n_cmp++;
    if ({ov, co, s} !== {1'b0, 1'b1, 32'h0}) begin
      n_bad++; $display("FAIL c32_res got %b%b %h want 01 00000000", ov, co, s);
    end
    do_op32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
    n_cmp++;
    if ({ov, co, s} !== {1'b1, 1'b0, 32'h80000000}) begin
      n_bad++; $display("FAIL c32_ovf got %b%b %h want 10 80000000", ov, co, s);
    end
  endtask

  task automatic test_exhaustive4();
    logic [5:0] q [$];
    logic [5:0] e;
    logic [3:0] ea, eb;
    logic       ec, es;
    int idx = 0;
    int got = 0;
    int first = -1;
    int cyc = 0;
    bus4.out_ready = 1'b1;
    for (cyc = 0; cyc < 700 && got < 512; cyc++) begin
      @(posedge clk); #1;
      ea = idx[3:0]; eb = idx[7:4]; es = idx[8]; ec = ea[0] ^ eb[1];
      bus4.in_valid = (idx < 512);
      bus4.a = ea; bus4.b = eb; bus4.sub = es; bus4.cin = ec;
      #1;
      if (bus4.in_valid && bus4.in_ready) begin
        q.push_back(model4(ea, eb, ec, es));
        idx++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (first < 0) first = cyc;
        e = (q.size() > 0) ? q.pop_front() : 6'h3F;
        n_cmp++;
        if ({bus4.ovf, bus4.cout, bus4.s} !== e) begin
          n_bad++; $display("FAIL w4_result %0d got %b want %b",
                            got, {bus4.ovf, bus4.cout, bus4.s}, e);
        end
        got++;
      end
    end
    bus4.in_valid = 1'b0;
    n_cmp++;
    if (first !== 4) begin
      n_bad++; $display("FAIL w4_latency got %0d want 4", first);
    end
    n_cmp++;
    if (got !== 512) begin
      n_bad++; $display("FAIL w4_count got %0d want 512", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
    bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b1;
    bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
    test_reset();
    test_carry();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    test_single_stage();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor of the 4-bit ripple adder: a WIDTH-bit add/subtract unit whose carry chain is split into CHUNK-bit slices, one slice per pipeline stage.
- Accepts one operation per cycle and delivers each result after a fixed latency of NSTAGE = WIDTH/CHUNK cycles.
- Uses a valid/ready handshake on both sides.
- Provides carry-out and signed-overflow flags.
- Serves as the wide-datapath adder for ALU and accumulator blocks where a single-cycle ripple chain misses timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage; CHUNK = WIDTH gives a single-stage registered adder.
- NSTAGE, WIDTH/CHUNK, derived localparam: pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: s = a + b + cin; 1: s = a - b (cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1; for sub=1, cout=1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NSTAGE-1) holds a valid bit and adds chunk k of a and bb plus the carry registered by stage k-1 (c0 for stage 0). Its CHUNK sum bits are registered.
- Unresolved upper chunks of a and bb travel down the pipe unchanged (operand skew). Resolved lower sum chunks are carried forward alongside them.
- The last stage also registers the carry into the MSB, used to form ovf.
- Stall: stall = out_valid & ~out_ready. While stall=1, every stage register (data and valid) holds its value.
- in_ready = ~stall, driven combinationally.
- No bubble collapsing: the whole pipe advances together.
- Accept: a transfer occurs when in_valid & in_ready. Stage 0's valid loads in_valid whenever not stalled.
- Latency: operands accepted at edge N appear on s/cout/ovf with out_valid=1 after edge N+NSTAGE-1, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready is held high.
- Outputs are registered, and s/cout/ovf are stable while out_valid=1 and out_ready=0.
- When out_valid=0, s/cout/ovf hold their last value; they carry no meaning.
- Reset (asynchronous, any time including mid-operation):
  - all valid bits clear to 0, so out_valid=0 and in_ready=1;
  - s=0, cout=0, ovf=0, internal data registers = 0.
  - In-flight operations are discarded. The first operation accepted after rst deasserts completes normally.
- In-flight operations never interact: each slot's carry and skewed operands belong only to that slot.
- Illegal parameterisation (WIDTH % CHUNK != 0, or CHUNK < 1) is an elaboration error.

Test Plan:
All cases use WIDTH=32, CHUNK=8, so latency is 4 unless noted.
- Carry ripple across all stages: a=0xFFFFFFFF, b=0, cin=1, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> s=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> s=0, cout=1, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 -> s=2, cout=1.
- Back-to-back with backpressure: stream 8 random ops with in_valid=1; drop out_ready for 3 cycles mid-stream. Required: in_ready=0 exactly while stalled, out_valid/s held stable, all 8 results match a reference model in order, none lost or duplicated.
- Reset mid-operation: assert rst asynchronously (between edges) with 3 ops in flight -> out_valid=0 and s=0 immediately. After release, a new op 0x10+0x20 returns s=0x30 with latency 4 and no stale results appear.
- Parameter corners: CHUNK=32 -> latency 1, 0xFFFFFFFF+1 gives s=0, cout=1. Also WIDTH=4, CHUNK=1 -> latency 4, exhaustive 4-bit add/sub check against a reference model.
